t07_mmio_responder: RTL and testbench

T07_MMIO_RESPONDER -- requirements
Module: t07_mmio_responder

---
 rtl/t07_mem_pkg.sv | 20 ++
 rtl/t07_mmio_responder.sv | 124 ++++++++++++
 tb/tb_t07_mmio_responder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/t07_mem_pkg.sv
// Shared memory-handler types: the request FSM states and the rwi command encoding.
package t07_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] RWI_IDLE  = 2'b00;
    localparam logic [1:0] RWI_WRITE = 2'b01;
    localparam logic [1:0] RWI_READ  = 2'b10;
    localparam logic [1:0] RWI_FETCH = 2'b11;

    function automatic logic is_misaligned(input logic [31:0] byte_addr);
        return byte_addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/t07_mmio_responder.sv
// Services one word request at a time against a req/ack backing memory, with abort on misalign or timeout.
// Latency: acceptance to busy low is 3 cycles at best; no new request is taken until the HOLD cycle has passed.
module t07_mmio_responder
    import t07_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  rwi,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [1:0]  lat_rwi;
    logic        lat_misal;
    logic        err_flag;
    logic [7:0]  cnt;
    logic        accept, done_ok, abort;
    logic        is_write;

    assign is_write = (lat_rwi == RWI_WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        mem_req = 1'b0;
        accept  = 1'b0;
        done_ok = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                if (rwi != RWI_IDLE) begin
                    accept  = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                // A misaligned request spends its ISSUE cycle without touching memory.
                if (lat_misal) begin
                    abort   = 1'b1;
                    state_n = RESP;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        done_ok = 1'b1;
                        state_n = RESP;
                    end else if (cnt == CNT_LAST) begin
                        abort   = 1'b1;
                        state_n = RESP;
                    end
                end
            end
            RESP: begin
                busy    = 1'b1;
                state_n = HOLD;
            end
            HOLD: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign mem_we = mem_req && is_write;
    assign err_o  = (state == RESP) && err_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_rwi   <= RWI_IDLE;
            lat_misal <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_flag  <= 1'b0;
            cnt       <= '0;
            rdata_o   <= '0;
        end else begin
            if (accept) begin
                lat_rwi   <= rwi;
                lat_misal <= is_misaligned(addr_i);
                mem_addr  <= addr_i[31:2];
                mem_wdata <= wdata_i;
                err_flag  <= 1'b0;
                cnt       <= '0;
            end else if (state == ISSUE) begin
                cnt <= cnt + 8'd1;
            end
            if (done_ok && !is_write) begin
                rdata_o <= mem_rdata;
            end
            if (abort) begin
                err_flag <= 1'b1;
                if (!is_write) begin
                    rdata_o <= ERR_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_t07_mmio_responder.sv
// Directed and randomized transactions against a transaction-level model of the responder.
module tb_t07_mmio_responder;

    localparam int          TIMEOUT  = 255;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rwi;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] model_rdata = '0;
    int gap;

    t07_mmio_responder #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .clk(clk), .rst(rst), .rwi(rwi), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy(busy), .rdata_o(rdata_o), .err_o(err_o),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request starting at a negedge; act as the memory, acking ack_dly cycles
    // after mem_req first rises (negative = never). Returns at the negedge of the HOLD cycle.
    task automatic do_req(input string tag, input logic [1:0] r, input logic [31:0] a,
                          input logic [31:0] wd, input int ack_dly, input logic [31:0] rd,
                          input bit hold, output int idle_gap);
        bit aligned, exp_err, started, fields_ok, finished;
        int exp_mreq, exp_busy, nb, nr, ne, cyc;
        logic [31:0] exp_rdata;

        aligned = (a[1:0] == 2'b00);
        if (!aligned)                            exp_mreq = 0;
        else if (ack_dly < 0 || ack_dly >= TIMEOUT) exp_mreq = TIMEOUT;
        else                                     exp_mreq = ack_dly + 1;
        exp_err   = !aligned || ack_dly < 0 || ack_dly >= TIMEOUT;
        exp_busy  = aligned ? exp_mreq + 1 : 2;
        exp_rdata = (r == 2'b01) ? model_rdata : (exp_err ? ERR_DATA : rd);

        rwi = r; addr_i = a; wdata_i = wd;
        nb = 0; nr = 0; ne = 0; cyc = 0; idle_gap = 0;
        started = 0; fields_ok = 1; finished = 0;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (!started) begin
                if (busy) begin
                    started = 1;
                    if (!hold) rwi = 2'b00;
                    addr_i  = $urandom;
                    wdata_i = $urandom;
                end else begin
                    idle_gap++;
                end
            end
            if (started) begin
                if (!busy) begin
                    finished = 1;
                    break;
                end
                nb++;
                if (err_o) ne++;
                if (mem_req) begin
                    if (mem_addr !== a[31:2] || mem_we !== (r == 2'b01) || mem_wdata !== wd)
                        fields_ok = 0;
                    if (nr == ack_dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rd;
                    end
                    nr++;
                end
            end
        end
        mem_ack = 1'b0;
        check({tag, " completed"}, 32'(finished), 32'd1);
        check({tag, " busy_cycles"}, nb, exp_busy);
        check({tag, " mem_req_cycles"}, nr, exp_mreq);
        check({tag, " err_pulses"}, ne, exp_err ? 1 : 0);
        check({tag, " mem_fields"}, 32'(fields_ok), 32'd1);
        check({tag, " rdata_o"}, rdata_o, exp_rdata);
        model_rdata = exp_rdata;
    endtask

    initial begin
        int ne, nb, cyc;
        logic [31:0] a, saved;
        rst = 1'b1; rwi = 2'b00; addr_i = '0; wdata_i = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset mem_req", mem_req, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_addr", {2'b00, mem_addr}, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset rdata_o", rdata_o, 0);
        check("reset err_o", err_o, 0);
        rst = 1'b0;
        @(negedge clk);

        do_req("fetch", 2'b11, 32'h0000_0010, 32'h0, 2, 32'h1234_5678, 0, gap);
        do_req("write", 2'b01, 32'h0000_0020, 32'hCAFE_F00D, 0, 32'h5555_AAAA, 0, gap);
        do_req("misalign", 2'b10, 32'h0000_0022, 32'h0, 0, 32'h1111_1111, 0, gap);
        do_req("timeout", 2'b10, 32'h0000_0100, 32'h0, -1, 32'h0, 0, gap);
        do_req("ack_at_limit", 2'b10, 32'h0000_0104, 32'h0, TIMEOUT - 1, 32'h0BAD_CAFE, 0, gap);
        do_req("misalign_write", 2'b01, 32'h0000_0031, 32'h7777_7777, 0, 32'h0, 0, gap);

        // Stray acks while idle must not alter anything.
        saved = rdata_o;
        repeat (2) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack rdata_o", rdata_o, saved);
        check("idle_ack busy", busy, 0);

        do_req("b2b_first", 2'b11, 32'h0000_0200, 32'h0, 1, 32'hA5A5_0001, 1, gap);
        do_req("b2b_second", 2'b11, 32'h0000_0204, 32'h0, 3, 32'hA5A5_0002, 1, gap);
        check("b2b_gap", gap, 1);
        rwi = 2'b00;

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            do_req($sformatf("rand%0d", i), 2'($urandom_range(3, 1)), a, $urandom,
                   int'($urandom_range(5)), $urandom, 0, gap);
        end

        // Reset in the middle of ISSUE, then a late ack.
        rwi = 2'b10; addr_i = 32'h0000_0040;
        cyc = 0;
        while (!mem_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid mem_req_seen", mem_req, 1);
        rwi = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rst_mid busy", busy, 0);
        check("rst_mid mem_req", mem_req, 0);
        check("rst_mid mem_we", mem_we, 0);
        check("rst_mid mem_addr", {2'b00, mem_addr}, 0);
        check("rst_mid mem_wdata", mem_wdata, 0);
        check("rst_mid rdata_o", rdata_o, 0);
        ne = 0; nb = 0;
        repeat (6) begin
            @(negedge clk);
            if (err_o) ne++;
            if (busy) nb++;
        end
        check("rst_mid err_o", ne, 0);
        check("rst_mid busy_after", nb, 0);
        check("rst_mid rdata_after", rdata_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
